// File: rtl/neureka_job_dispatcher.sv
// Job dispatcher: queues offload requests from cores, hands each one to an idle engine,
// and raises per-core completion and dispatcher-idle events.
module neureka_job_dispatcher #(
  parameter int N_ENGINES     = 2,
  parameter int N_CONTEXT     = 2,
  parameter int N_CORES       = 8,
  parameter int REGFILE_N_EVT = 2,
  parameter int ID_W          = 8,
  parameter int ARB_RR        = 0,
  localparam int CW           = (N_CORES > 1) ? $clog2(N_CORES) : 1,
  localparam int QCW          = $clog2(N_CONTEXT) + 1
) (
  input  logic                                      clk_i,
  input  logic                                      rst_i,
  input  logic                                      job_valid_i,
  output logic                                      job_ready_o,
  input  logic [ID_W-1:0]                           job_id_i,
  input  logic [CW-1:0]                             job_core_i,
  output logic [N_ENGINES-1:0]                      eng_start_o,
  input  logic [N_ENGINES-1:0]                      eng_busy_i,
  input  logic [N_ENGINES-1:0]                      eng_done_i,
  output logic [N_ENGINES-1:0][ID_W-1:0]            eng_job_id_o,
  output logic [N_ENGINES-1:0]                      enable_o,
  output logic [N_CORES-1:0][REGFILE_N_EVT-1:0]     evt_o,
  output logic                                      busy_o,
  output logic [QCW-1:0]                            queue_count_o
);

  localparam int PW = $clog2(N_CONTEXT);
  localparam int EW = (N_ENGINES > 1) ? $clog2(N_ENGINES) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;

  // ---------------------------------------------------------------------------
  // Job queue
  // ---------------------------------------------------------------------------
  logic [ID_W-1:0] r_q_id   [N_CONTEXT];
  logic [CW-1:0]   r_q_core [N_CONTEXT];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [QCW-1:0]  r_count;

  logic            w_push;
  logic            w_pop;
  logic [ID_W-1:0] w_head_id;
  logic [CW-1:0]   w_head_core;

  // Readiness is taken from the registered count only, so a pop in the same
  // cycle never opens a slot for a push into a full queue.
  assign job_ready_o   = (r_count < QCW'(N_CONTEXT));
  assign w_push        = job_valid_i && job_ready_o;
  assign w_head_id     = r_q_id[r_rd_ptr];
  assign w_head_core   = r_q_core[r_rd_ptr];
  assign queue_count_o = r_count;

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_q_id[r_wr_ptr]   <= job_id_i;
      r_q_core[r_wr_ptr] <= job_core_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (!w_push && w_pop) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  logic [N_ENGINES-1:0] w_elig;
  logic [EW-1:0]        r_rr_ptr;
  logic [EW-1:0]        w_sel;
  logic                 w_found;

  // Round-robin searches [ptr, N) first, then wraps to [0, ptr).
  always_comb begin
    w_sel   = '0;
    w_found = 1'b0;
    for (int e = 0; e < N_ENGINES; e++) begin
      if (!w_found && w_elig[e] && ((ARB_RR == 0) || (EW'(e) >= r_rr_ptr))) begin
        w_found = 1'b1;
        w_sel   = EW'(e);
      end
    end
    for (int e = 0; e < N_ENGINES; e++) begin
      if (!w_found && w_elig[e]) begin
        w_found = 1'b1;
        w_sel   = EW'(e);
      end
    end
  end

  assign w_pop = (r_count != '0) && w_found;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rr_ptr <= '0;
    end else if (w_pop) begin
      r_rr_ptr <= (w_sel == EW'(N_ENGINES - 1)) ? '0 : (w_sel + 1'b1);
    end
  end

  // ---------------------------------------------------------------------------
  // Per-engine control
  // ---------------------------------------------------------------------------
  logic [N_ENGINES-1:0] w_fin;
  logic [CW-1:0]        w_eng_core [N_ENGINES];

  genvar gi;
  generate
    for (gi = 0; gi < N_ENGINES; gi++) begin : g_eng
      logic [1:0]      r_state;
      logic [ID_W-1:0] r_job_id;
      logic [CW-1:0]   r_core;
      logic            w_disp;

      assign w_disp = w_pop && (w_sel == EW'(gi));

      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          r_state  <= ST_IDLE;
          r_job_id <= '0;
          r_core   <= '0;
        end else begin
          case (r_state)
            ST_IDLE: begin
              if (w_disp) begin
                r_state  <= ST_START;
                r_job_id <= w_head_id;
                r_core   <= w_head_core;
              end
            end
            ST_START: r_state <= ST_RUN;
            ST_RUN: begin
              if (eng_done_i[gi]) begin
                r_state <= ST_IDLE;
              end
            end
            default: r_state <= ST_IDLE;
          endcase
        end
      end

      assign w_elig[gi]       = (r_state == ST_IDLE) && !eng_busy_i[gi];
      assign eng_start_o[gi]  = (r_state == ST_START);
      assign enable_o[gi]     = (r_state != ST_IDLE);
      assign eng_job_id_o[gi] = r_job_id;
      assign w_fin[gi]        = (r_state == ST_RUN) && eng_done_i[gi];
      assign w_eng_core[gi]   = r_core;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Busy and events
  // ---------------------------------------------------------------------------
  logic                                  w_busy;
  logic                                  r_busy_d;
  logic                                  w_busy_fall;
  logic [N_CORES-1:0]                    w_done_hit;
  logic [N_CORES-1:0][REGFILE_N_EVT-1:0] w_evt_next;
  logic [N_CORES-1:0][REGFILE_N_EVT-1:0] r_evt;

  assign w_busy      = (r_count != '0) || (|enable_o);
  assign busy_o      = w_busy;
  assign w_busy_fall = r_busy_d && !w_busy;

  // Completions targeting the same core merge into a single pulse.
  always_comb begin
    w_done_hit = '0;
    for (int e = 0; e < N_ENGINES; e++) begin
      if (w_fin[e]) begin
        w_done_hit[w_eng_core[e]] = 1'b1;
      end
    end
  end

  generate
    for (gi = 0; gi < N_CORES; gi++) begin : g_evt
      assign w_evt_next[gi][0] = w_done_hit[gi];
      if (REGFILE_N_EVT > 1) begin : g_idle_evt
        assign w_evt_next[gi][1] = w_busy_fall;
      end
      if (REGFILE_N_EVT > 2) begin : g_unused_evt
        assign w_evt_next[gi][REGFILE_N_EVT-1:2] = '0;
      end
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_busy_d <= 1'b0;
      r_evt    <= '0;
    end else begin
      r_busy_d <= w_busy;
      r_evt    <= w_evt_next;
    end
  end

  assign evt_o = r_evt;

endmodule

// File: tb/tb_neureka_job_dispatcher.sv
// Directed bench: fixed-priority dispatcher (2 engines) and round-robin dispatcher (4 engines)
// driven cycle by cycle, with outputs sampled on the falling clock edge.
module tb_neureka_job_dispatcher;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // fixed-priority instance, 2 engines
  logic             job_valid = 1'b0;
  logic             job_ready;
  logic [7:0]       job_id = '0;
  logic [2:0]       job_core = '0;
  logic [1:0]       eng_start;
  logic [1:0]       eng_busy = '0;
  logic [1:0]       eng_done = '0;
  logic [1:0][7:0]  eng_job_id;
  logic [1:0]       enable;
  logic [7:0][1:0]  evt;
  logic             busy;
  logic [1:0]       qcount;

  // round-robin instance, 4 engines
  logic             r_valid = 1'b0;
  logic             r_ready;
  logic [7:0]       r_id = '0;
  logic [2:0]       r_core = '0;
  logic [3:0]       r_start;
  logic [3:0]       r_busy_in = '0;
  logic [3:0]       r_done = '0;
  logic [3:0][7:0]  r_job_id;
  logic [3:0]       r_enable;
  logic [7:0][1:0]  r_evt;
  logic             r_busy;
  logic [1:0]       r_qcount;

  int total = 0;
  int bad   = 0;

  neureka_job_dispatcher dut (
    .clk_i(clk), .rst_i(rst),
    .job_valid_i(job_valid), .job_ready_o(job_ready),
    .job_id_i(job_id), .job_core_i(job_core),
    .eng_start_o(eng_start), .eng_busy_i(eng_busy), .eng_done_i(eng_done),
    .eng_job_id_o(eng_job_id), .enable_o(enable), .evt_o(evt),
    .busy_o(busy), .queue_count_o(qcount)
  );

  neureka_job_dispatcher #(.N_ENGINES(4), .ARB_RR(1)) dut_rr (
    .clk_i(clk), .rst_i(rst),
    .job_valid_i(r_valid), .job_ready_o(r_ready),
    .job_id_i(r_id), .job_core_i(r_core),
    .eng_start_o(r_start), .eng_busy_i(r_busy_in), .eng_done_i(r_done),
    .eng_job_id_o(r_job_id), .enable_o(r_enable), .evt_o(r_evt),
    .busy_o(r_busy), .queue_count_o(r_qcount)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
      $display("ok   %s = %0h", tag, obs);
    else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  initial begin
    repeat (3) tick();
    rst = 1'b0;

    // reset state, then single job 0x11 for core 3 (cycle t)
    chk("rst_ready", job_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_count", qcount, 0);
    chk("rst_start", eng_start, 0);
    chk("rst_enable", enable, 0);
    chk("rst_evt", evt, 0);
    chk("rst_jobid", eng_job_id, 0);
    chk("rr_rst_ready", r_ready, 1);
    job_valid = 1'b1; job_id = 8'h11; job_core = 3'd3;
    tick(); // t+1
    job_valid = 1'b0;
    chk("t1_count", qcount, 1);
    chk("t1_start", eng_start, 0);
    tick(); // t+2
    chk("t2_start", eng_start, 2'b01);
    chk("t2_jobid0", eng_job_id[0], 8'h11);
    chk("t2_enable", enable, 2'b01);
    chk("t2_count", qcount, 0);
    tick(); // t+3
    chk("t3_start", eng_start, 0);
    chk("t3_enable", enable, 2'b01);
    repeat (7) tick(); // t+10
    chk("t10_busy", busy, 1);
    chk("t10_evt", evt, 0);
    eng_done = 2'b01;
    tick(); // t+11
    eng_done = 2'b00;
    chk("t11_evt_done", evt, 16'h0040);
    chk("t11_enable", enable, 0);
    chk("t11_busy", busy, 0);
    tick();
    chk("t12_evt_idle", evt, 16'hAAAA);
    tick();
    chk("t13_evt_clear", evt, 0);

    // fill queue with both engines busy; 4 offered, 2 accepted
    eng_busy = 2'b11;
    job_valid = 1'b1; job_id = 8'h21; job_core = 3'd5;
    tick();
    chk("fill1_count", qcount, 1);
    chk("fill1_ready", job_ready, 1);
    job_id = 8'h22;
    tick();
    chk("fill2_count", qcount, 2);
    chk("fill2_ready", job_ready, 0);
    job_id = 8'h23;
    tick();
    chk("fill3_count", qcount, 2);
    job_id = 8'h24;
    tick();
    chk("fill4_count", qcount, 2);
    chk("fill4_ready", job_ready, 0);
    // pop while full with valid still high: no push this cycle
    job_id = 8'h25;
    eng_busy = 2'b00;
    tick();
    job_valid = 1'b0;
    chk("drain1_count", qcount, 1);
    chk("drain1_start", eng_start, 2'b01);
    chk("drain1_jobid", eng_job_id, 16'h0021);
    tick();
    chk("drain2_start", eng_start, 2'b10);
    chk("drain2_jobid", eng_job_id, 16'h2221);
    chk("drain2_count", qcount, 0);
    tick();
    chk("drain3_count", qcount, 0);
    chk("drain3_start", eng_start, 0);
    eng_done = 2'b11; // both complete, same core 5
    tick();
    eng_done = 2'b00;
    chk("same_core_evt", evt, 16'h0400);
    tick();
    chk("same_core_idle_evt", evt, 16'hAAAA);

    // two jobs for cores 1 and 2 complete together
    job_valid = 1'b1; job_id = 8'h31; job_core = 3'd1;
    tick();
    chk("dc1_count", qcount, 1);
    job_id = 8'h32; job_core = 3'd2;
    tick();
    job_valid = 1'b0;
    chk("dc2_start", eng_start, 2'b01);
    chk("dc2_count", qcount, 1);
    tick();
    chk("dc3_start", eng_start, 2'b10);
    chk("dc3_count", qcount, 0);
    tick();
    eng_done = 2'b11;
    tick();
    eng_done = 2'b00;
    chk("diff_core_evt", evt, 16'h0014);
    tick();
    chk("diff_core_idle_evt", evt, 16'hAAAA);

    // engine 0 reports busy while idle: job goes to engine 1
    eng_busy = 2'b01;
    job_valid = 1'b1; job_id = 8'h41; job_core = 3'd0;
    tick();
    job_valid = 1'b0;
    chk("skip1_count", qcount, 1);
    tick();
    chk("skip_start", eng_start, 2'b10);
    chk("skip_jobid", eng_job_id, 16'h4131);
    chk("skip_enable", enable, 2'b10);
    tick();
    eng_busy = 2'b00;
    eng_done = 2'b10;
    tick();
    eng_done = 2'b00;
    chk("skip_evt", evt, 16'h0001);
    chk("skip_enable_off", enable, 0);
    tick();
    chk("skip_idle_evt", evt, 16'hAAAA);

    // reset with engine 1 running and two jobs queued
    eng_busy = 2'b01;
    job_valid = 1'b1; job_id = 8'h51; job_core = 3'd4;
    tick();
    job_id = 8'h52;
    tick();
    chk("mr_start", eng_start, 2'b10);
    chk("mr_count1", qcount, 1);
    job_id = 8'h53;
    tick();
    job_valid = 1'b0;
    chk("mr_count2", qcount, 2);
    chk("mr_enable", enable, 2'b10);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    eng_busy = 2'b00;
    chk("mr_rst_start", eng_start, 0);
    chk("mr_rst_enable", enable, 0);
    chk("mr_rst_evt", evt, 0);
    chk("mr_rst_busy", busy, 0);
    chk("mr_rst_count", qcount, 0);
    chk("mr_rst_jobid", eng_job_id, 0);
    chk("mr_rst_ready", job_ready, 1);
    eng_done = 2'b10; // stale completion after reset
    tick();
    eng_done = 2'b00;
    chk("mr_late_evt", evt, 0);
    chk("mr_late_busy", busy, 0);
    tick();
    chk("mr_late_evt2", evt, 0);

    // round-robin: four back-to-back jobs spread over engines 0..3
    r_valid = 1'b1; r_id = 8'h61; r_core = 3'd0;
    tick();
    r_id = 8'h62; r_core = 3'd1;
    tick();
    chk("rr_start0", r_start, 4'b0001);
    chk("rr_count_steady", r_qcount, 1);
    r_id = 8'h63; r_core = 3'd2;
    tick();
    chk("rr_start1", r_start, 4'b0010);
    r_id = 8'h64; r_core = 3'd3;
    tick();
    r_valid = 1'b0;
    chk("rr_start2", r_start, 4'b0100);
    tick();
    chk("rr_start3", r_start, 4'b1000);
    r_done = 4'b0001;
    tick();
    r_done = 4'b0000;
    chk("rr_evt_e0", r_evt, 16'h0001);
    r_valid = 1'b1; r_id = 8'h65; r_core = 3'd0;
    tick();
    r_valid = 1'b0;
    chk("rr5_count", r_qcount, 1);
    tick();
    chk("rr5_start", r_start, 4'b0001);
    chk("rr5_jobid", r_job_id, 32'h64636265);
    tick();
    r_done = 4'b0101; // engines 0 and 2 free; pointer now 1
    tick();
    r_done = 4'b0000;
    r_valid = 1'b1; r_id = 8'h66; r_core = 3'd6;
    tick();
    r_valid = 1'b0;
    tick();
    chk("rr6_start", r_start, 4'b0100);
    chk("rr6_jobid", r_job_id, 32'h64666265);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/neureka_job_dispatcher.md
NEUREKA_JOB_DISPATCHER -- requirements
Module: neureka_job_dispatcher

Interface
REQ-001 SHALL have parameter N_ENGINES, default 2, number of engine instances served (1..8).
REQ-002 SHALL have parameter N_CONTEXT, default 2, job queue depth (power of two, >=2).
REQ-003 SHALL have parameter N_CORES, default 8, number of event targets; CW = $clog2(N_CORES).
REQ-004 SHALL have parameter REGFILE_N_EVT, default 2, events per core.
REQ-005 SHALL have parameter ID_W, default 8, job ID width.
REQ-006 SHALL have parameter ARB_RR, default 0, arbitration mode (0 = fixed lowest-index idle engine, 1 = round-robin).
REQ-007 SHALL have ports: one clock; reset is synchronous and active-high.
REQ-008 clk_i  in  1  clock, all state on rising edge.
REQ-009 rst_i  in  1  synchronous active-high reset.
REQ-010 job_valid_i  in  1  offload request valid.
REQ-011 job_ready_o  out  1  queue can accept a job.
REQ-012 job_id_i  in  ID_W  job ID.
REQ-013 job_core_i  in  CW  requesting core index.
REQ-014 eng_start_o  out  N_ENGINES  one-cycle start pulse per engine.
REQ-015 eng_busy_i  in  N_ENGINES  engine-reported busy.
REQ-016 eng_done_i  in  N_ENGINES  engine completion pulse.
REQ-017 eng_job_id_o  out  N_ENGINES x ID_W  ID of job dispatched to each engine.
REQ-018 enable_o  out  N_ENGINES  per-engine enable.
REQ-019 evt_o  out  N_CORES x REGFILE_N_EVT  event pulses to cores.
REQ-020 busy_o  out  1  dispatcher busy.
REQ-021 queue_count_o  out  $clog2(N_CONTEXT)+1  jobs held in queue.

Function
REQ-022 Queue SHALL be FIFO of {job_id, job_core}; push when job_valid_i && job_ready_o.
REQ-023 job_ready_o SHALL equal (queue_count_o < N_CONTEXT) from registered count only; no push when full, even with simultaneous pop.
REQ-024 Simultaneous push and pop SHALL leave count unchanged; no empty-queue bypass.
REQ-025 Per-engine FSM SHALL have states IDLE, START, RUN.
REQ-026 Engine is eligible when state==IDLE and eng_busy_i[e]==0.
REQ-027 Each cycle, if queue non-empty and any engine eligible, head SHALL be popped and assigned to exactly one engine; at most one dispatch per cycle.
REQ-028 ARB_RR=0: lowest-index eligible engine. ARB_RR=1: first eligible engine at or after pointer; pointer SHALL move to chosen+1 (mod N_ENGINES) after each dispatch; reset value 0.
REQ-029 On dispatch engine SHALL go IDLE->START, latch job_id into eng_job_id_o[e] and job_core internally; eng_job_id_o holds until next dispatch to that engine.
REQ-030 eng_start_o[e] SHALL be 1 exactly while state==START (one cycle), then START->RUN.
REQ-031 RUN->IDLE SHALL occur on eng_done_i[e]; eng_done_i ignored in IDLE and START.
REQ-032 Latency: job pushed in cycle t into empty queue with eligible engine -> eng_start_o at cycle t+2.
REQ-033 An engine returning to IDLE SHALL be eligible no earlier than the following cycle.
REQ-034 evt_o[c][0] SHALL pulse one cycle after the cycle eng_done_i is sampled in RUN, c = latched core; simultaneous completions for the same core SHALL OR into one pulse.
REQ-035 evt_o[c][1] SHALL pulse for all c in the cycle after busy_o falls 1->0; other evt bits (index >=2) SHALL be 0.
REQ-036 busy_o SHALL equal (queue_count_o != 0) or any engine state != IDLE.
REQ-037 enable_o[e] SHALL equal (state[e] != IDLE).

Reset
REQ-038 On rst_i: queue empty, count 0, all FSMs IDLE, RR pointer 0, eng_job_id_o 0, eng_start_o 0, enable_o 0, evt_o 0, busy_o 0, job_ready_o 1 from next cycle.
REQ-039 Reset mid-operation SHALL drop queued and in-flight jobs without events; eng_done_i arriving after reset SHALL be ignored.

Verification
REQ-040 N_ENGINES=2, ARB_RR=0: push ID 0x11 core 3 at t -> eng_start_o=2'b01 at t+2, eng_job_id_o[0]=0x11; done at t+10 -> evt_o[3][0] at t+11, evt_o[*][1] at t+12.
REQ-041 Fill: push N_CONTEXT+2 jobs with both engines busy -> job_ready_o=0 after N_CONTEXT pushes; queue_count_o=N_CONTEXT; no extra job lost or accepted.
REQ-042 ARB_RR=1, 4 engines all idle, 4 jobs back-to-back -> starts on engines 0,1,2,3 in consecutive cycles; 5th job after engine 0 done -> engine 0 at pointer 0.
REQ-043 Both engines done same cycle, same core 5 -> single evt_o[5][0] pulse; different cores 1,2 -> both pulse same cycle.
REQ-044 rst_i asserted while engine 1 in RUN and 2 jobs queued -> all outputs zero next cycle; later eng_done_i[1] produces no event.
REQ-045 eng_busy_i[0]=1 while FSM IDLE -> job dispatched to engine 1 (ARB_RR=0).
